// File: rtl/uart_tx_engine_if.sv
// -----------------------------------------------------------------------------
// uart_tx_engine_if
// Read-side connection between the TX FIFO and the UART transmit engine.
//
// Signals:
//   rd_en      one-cycle pop request issued by the engine
//   f_empty    FIFO empty flag
//   fifo_dout  FIFO read data, valid the cycle after rd_en
//
// Modports:
//   master  engine side (drives rd_en, observes f_empty / fifo_dout)
//   slave   FIFO side   (observes rd_en, drives f_empty / fifo_dout)
// -----------------------------------------------------------------------------
interface uart_tx_engine_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rd_en;
  logic                  f_empty;
  logic [DATA_WIDTH-1:0] fifo_dout;

  modport master (
    output rd_en,
    input  f_empty,
    input  fifo_dout
  );

  modport slave (
    input  rd_en,
    output f_empty,
    output fifo_dout
  );
endinterface

// File: rtl/uart_tx_engine.sv
// -----------------------------------------------------------------------------
// uart_tx_engine
// UART transmit serializer fed from a TX FIFO. Pops one byte at a time and
// shifts it out as start / data (LSB first) / optional parity / stop bits.
// Bit timing comes from an internal baud counter.
//
// Ports:
//   clk      system clock, rising edge
//   n_rst    asynchronous active-low reset
//   tx_en    level enable; only gates the start of new frames
//   fifo     FIFO read port (master modport: rd_en out, f_empty/fifo_dout in)
//   tx       registered serial line, idle high
//   busy     high in every state except IDLE
//   tx_done  one-cycle pulse in the final cycle of the last stop bit
// -----------------------------------------------------------------------------
module uart_tx_engine #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    tx_en,
  uart_tx_engine_if.master        fifo,
  output logic                    tx,
  output logic                    busy,
  output logic                    tx_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  // The bit counter is shared by DATA (0..DATA_WIDTH-1) and STOP
  // (0..STOP_BITS-1); STOP_BITS never exceeds 2, so DATA sets the width.
  localparam int BIT_W  = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state_reg;
  state_t                state_next;
  logic [BAUD_W-1:0]     baud_cnt_reg;
  logic [BIT_W-1:0]      bit_cnt_reg;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  parity_bit_reg;
  logic                  tx_reg;
  logic                  tx_next;

  logic                  bit_tick;
  logic                  data_last;
  logic                  stop_last;
  logic [DATA_WIDTH-1:0] shift_down;

  assign bit_tick   = (baud_cnt_reg == BAUD_LAST);
  assign data_last  = (bit_cnt_reg == DATA_LAST);
  assign stop_last  = (bit_cnt_reg == STOP_LAST);
  assign shift_down = shift_reg >> 1;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and next line level. tx is registered, so the level for the
  // bit being entered is chosen here on the transition into it.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    tx_next    = tx_reg;
    case (state_reg)
      IDLE: begin
        tx_next = 1'b1;
        if (tx_en && !fifo.f_empty) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        tx_next    = 1'b1;
        state_next = LOAD;
      end
      LOAD: begin
        tx_next    = 1'b0;
        state_next = START;
      end
      START: begin
        if (bit_tick) begin
          tx_next    = shift_reg[0];
          state_next = DATA;
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (data_last) begin
            if (PARITY_EN != 0) begin
              tx_next    = parity_bit_reg;
              state_next = PARITY;
            end else begin
              tx_next    = 1'b1;
              state_next = STOP;
            end
          end else begin
            // shift_reg is shifted on this same edge; its next LSB is
            // the bit being entered.
            tx_next = shift_down[0];
          end
        end
      end
      PARITY: begin
        if (bit_tick) begin
          tx_next    = 1'b1;
          state_next = STOP;
        end
      end
      STOP: begin
        if (bit_tick && stop_last) begin
          tx_next    = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        tx_next    = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: baud counter, bit counter, shift register, parity, line register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      baud_cnt_reg   <= '0;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      parity_bit_reg <= 1'b0;
      tx_reg         <= 1'b1;
    end else begin
      tx_reg <= tx_next;
      case (state_reg)
        LOAD: begin
          shift_reg      <= fifo.fifo_dout;
          parity_bit_reg <= (^fifo.fifo_dout) ^ (PARITY_ODD != 0);
          baud_cnt_reg   <= '0;
          bit_cnt_reg    <= '0;
        end
        START, PARITY: begin
          if (bit_tick) begin
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        DATA: begin
          if (bit_tick) begin
            baud_cnt_reg <= '0;
            shift_reg    <= shift_down;
            bit_cnt_reg  <= data_last ? '0 : bit_cnt_reg + 1'b1;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        STOP: begin
          if (bit_tick) begin
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= stop_last ? '0 : bit_cnt_reg + 1'b1;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        default: begin
          baud_cnt_reg <= '0;
          bit_cnt_reg  <= '0;
        end
      endcase
    end
  end

  // FETCH is only reachable after f_empty was seen low in IDLE, and this
  // block is the only reader, so a pop can never hit an empty FIFO.
  assign fifo.rd_en = (state_reg == FETCH);
  assign busy       = (state_reg != IDLE);
  assign tx_done    = (state_reg == STOP) && bit_tick && stop_last;
  assign tx         = tx_reg;

endmodule

// File: doc/uart_tx_engine.md
# uart_tx_engine

UART transmit serializer that sits directly downstream of the TX FIFO: it pops one byte at a time from the FIFO read port and shifts it onto the serial line as a start/data/parity/stop frame. The FIFO's write side is owned by the host; this block owns the FIFO's `rd_en` and watches `f_empty`. Baud timing comes from an internal clock-divider counter, so no external tick is needed.

## Interface
- `DATA_WIDTH`, 8: bits per frame; must match the FIFO data width.
- `CLKS_PER_BIT`, 868: clock cycles per serial bit (100 MHz / 115200); minimum 2.
- `PARITY_EN`, 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd parity; ignored when `PARITY_EN`=0.
- `STOP_BITS`, 1: number of stop bits; legal values are 1 and 2.

- `clk`  in  1  single system clock, rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `tx_en`  in  1  level enable; gates the start of new frames only.
- `f_empty`  in  1  TX FIFO empty flag.
- `fifo_dout`  in  DATA_WIDTH  TX FIFO read data; valid the cycle after `rd_en`.
- `rd_en`  out  1  one-cycle FIFO pop request.
- `tx`  out  1  serial line; idle high; registered.
- `busy`  out  1  high in every state except IDLE.
- `tx_done`  out  1  one-cycle pulse in the final cycle of the last stop bit.

## Operation
- Reset, async assert: `tx`=1, `rd_en`=0, `busy`=0, `tx_done`=0; state IDLE; baud counter, bit counter and shift register cleared. Reset is effective immediately, also mid-frame; the partial frame is abandoned and its byte is lost.
- States: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE: go to FETCH when `tx_en`=1 and `f_empty`=0. Otherwise stay in IDLE.
- FETCH: `rd_en`=1 for exactly this one cycle. Go to LOAD unconditionally.
- LOAD: capture `fifo_dout` into the shift register and compute parity (XOR of the data bits, inverted when `PARITY_ODD`=1). Go to START.
- START: `tx`=0 for CLKS_PER_BIT cycles.
- DATA: `DATA_WIDTH` bits, LSB first, each held for CLKS_PER_BIT cycles. The bit counter runs 0..DATA_WIDTH-1.
- PARITY: entered only when `PARITY_EN`=1; `tx` holds the parity bit for CLKS_PER_BIT cycles.
- STOP: `tx`=1 for STOP_BITS×CLKS_PER_BIT cycles. `tx_done` is high in the last of those cycles. Then go to IDLE.
- Baud counter:
  - width $clog2(CLKS_PER_BIT);
  - counts 0..CLKS_PER_BIT-1;
  - reloads to 0 on every bit boundary and on leaving LOAD.
- `tx_en` deasserted mid-frame: the current frame completes normally. No further FETCH happens while `tx_en` is low.
- `f_empty` changing during a frame: no effect. It is sampled only in IDLE.
- `rd_en` is never asserted while `f_empty`=1, so there is no underflow pop.

## Timing
- `tx` is registered. It changes on the clock edge that enters a new bit or state.
- Idle-to-line latency: `f_empty` is seen low in IDLE at cycle 0; `rd_en` is high in cycle 1; data is captured in cycle 2; `tx` falls at the start of cycle 3.
- Frame length: CLKS_PER_BIT×(1+DATA_WIDTH+PARITY_EN+STOP_BITS) cycles, measured from the `tx` falling edge to the end of the `tx_done` cycle.
- Back-to-back frames: `tx` stays high for exactly 3 extra cycles (IDLE, FETCH, LOAD) between the last stop cycle and the next start bit.
- `busy` rises in the FETCH cycle and falls in the cycle after `tx_done`.

## Test plan
- Basic frame: CLKS_PER_BIT=4, no parity, 1 stop; FIFO holds 0xA5.
  - `rd_en` pulses once.
  - `tx` sequence, 4 cycles per bit: 0, 1,0,1,0,0,1,0,1, 1.
  - `tx_done` fires 40 cycles after the `tx` falling edge starts.
- Parity:
  - `PARITY_EN`=1, even, byte 0xA5 → parity bit 0; frame is 44 cycles.
  - With `PARITY_ODD`=1 → parity bit 1.
  - Byte 0x07 with even parity → parity bit 1.
- Two stop bits: `STOP_BITS`=2, byte 0x00 → 8 low data bits, then `tx` high for 8 cycles; `tx_done` is in the 8th of those cycles.
- Back-to-back: FIFO holds 0x55 and 0x0F → two `rd_en` pulses, two `tx_done` pulses, and exactly 3 idle-high cycles between frames; `rd_en` never fires after `f_empty` goes high.
- Enable gating:
  - `tx_en`=0 with a non-empty FIFO → no `rd_en` and `tx` stays 1 for 100 cycles.
  - Drop `tx_en` during DATA → the frame finishes, with no further pop.
- Mid-frame reset: assert `n_rst` during data bit 3 → `tx`=1, `busy`=0 and `rd_en`=0 immediately. After release, the next non-empty FIFO entry starts a clean frame.
